// File: rtl/corner_scan_controller_if.sv
// Corner-coordinate stream: valid/ready handshake carrying the window centre of
// each detected corner from the scan controller to its consumer.
interface corner_scan_controller_if;
    logic       corner_valid;
    logic       corner_ready;
    logic [8:0] corner_x;
    logic [7:0] corner_y;

    modport master (
        output corner_valid,
        output corner_x,
        output corner_y,
        input  corner_ready
    );

    modport slave (
        input  corner_valid,
        input  corner_x,
        input  corner_y,
        output corner_ready
    );
endinterface

// File: rtl/corner_scan_controller.sv
// Corner scan controller: walks the raster of one frame of 5x5 windows, counts
// corners on interior windows and queues their window-centre coordinates in a
// first-word-fall-through FIFO that the consumer drains at its own pace.
module corner_scan_controller #(
    parameter int unsigned IMG_WIDTH  = 320,
    parameter int unsigned IMG_HEIGHT = 240,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            frame_start,
    input  logic                            pix_valid,
    input  logic                            corner_in,
    output logic                            busy,
    output logic                            frame_done,
    output logic [7:0]                      corner_count,
    output logic                            overflow,
    corner_scan_controller_if.master        corner_if
);

    localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
    localparam int unsigned XLastI   = IMG_WIDTH - 1;
    localparam int unsigned YLastI   = IMG_HEIGHT - 1;
    localparam logic [8:0]  XLast    = XLastI[8:0];
    localparam logic [7:0]  YLast    = YLastI[7:0];
    localparam logic [PtrW:0]   FillFull = FIFO_DEPTH[PtrW:0];
    localparam logic [PtrW:0]   FillOne  = 1;
    localparam logic [PtrW-1:0] PtrOne   = 1;

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e          r_state;
    logic [8:0]      r_x;
    logic [7:0]      r_y;
    logic [7:0]      r_count;
    logic            r_overflow;

    // FIFO entries are {centre_x, centre_y}
    logic [16:0]     r_mem [FIFO_DEPTH];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [PtrW:0]   r_fill;

    logic            w_interior;
    logic            w_accept;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic [16:0]     w_head;

    assign w_interior = (r_x >= 9'd4) && (r_y >= 8'd4);
    assign w_accept   = (r_state == StScan) && pix_valid && corner_in && w_interior;
    assign w_full     = (r_fill == FillFull);
    assign w_pop      = corner_if.corner_valid && corner_if.corner_ready;
    // A full FIFO still takes the push when the head leaves in the same cycle
    assign w_push     = w_accept && (!w_full || w_pop);
    assign w_head     = r_mem[r_rd_ptr];

    assign busy         = (r_state == StScan);
    assign frame_done   = (r_state == StDone);
    assign corner_count = r_count;
    assign overflow     = r_overflow;

    // Head is gated so the coordinate bus reads zero whenever the FIFO is empty
    assign corner_if.corner_valid = (r_fill != '0);
    assign corner_if.corner_x     = corner_if.corner_valid ? w_head[16:8] : 9'd0;
    assign corner_if.corner_y     = corner_if.corner_valid ? w_head[7:0]  : 8'd0;

    // Frame FSM: raster position, saturating corner count and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_x        <= '0;
            r_y        <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (frame_start) begin
                        r_state    <= StScan;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                StScan: begin
                    if (pix_valid) begin
                        if (w_accept) begin
                            if (r_count != 8'hFF) begin
                                r_count <= r_count + 8'd1;
                            end
                            if (!w_push) begin
                                r_overflow <= 1'b1;
                            end
                        end
                        if (r_x == XLast) begin
                            r_x <= '0;
                            if (r_y == YLast) begin
                                r_state <= StDone;
                            end else begin
                                r_y <= r_y + 8'd1;
                            end
                        end else begin
                            r_x <= r_x + 9'd1;
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; reset empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PtrOne;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrOne;
            end
            if (w_push && !w_pop) begin
                r_fill <= r_fill + FillOne;
            end else if (!w_push && w_pop) begin
                r_fill <= r_fill - FillOne;
            end
        end
    end

    // FIFO storage writes the window centre of each accepted corner.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_x - 9'd2, r_y - 8'd2};
        end
    end

endmodule

// File: tb/tb_corner_scan_controller.sv
// Self-checking bench for corner_scan_controller: a cycle model with a
// scoreboard queue of expected FIFO entries, plus scenario checks.
module tb_corner_scan_controller;

    // Reduced frame so several full frames fit a short run
    localparam int IW    = 40;
    localparam int IH    = 24;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic       pix_valid;
    logic       corner_in;
    logic       busy;
    logic       frame_done;
    logic [7:0] corner_count;
    logic       overflow;

    corner_scan_controller_if cif();

    corner_scan_controller #(
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .pix_valid    (pix_valid),
        .corner_in    (corner_in),
        .busy         (busy),
        .frame_done   (frame_done),
        .corner_count (corner_count),
        .overflow     (overflow),
        .corner_if    (cif)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_state, m_x, m_y, m_cnt;
    bit          m_ovf;
    int          n_done;
    logic [16:0] sb_q[$];
    logic [16:0] pop_log[$];
    logic [16:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [16:0] log_entry(input int i);
        return (i < pop_log.size()) ? pop_log[i] : 17'h1FFFF;
    endfunction

    function automatic int log_x(input int i);
        logic [16:0] e;
        e = log_entry(i);
        return int'(e[16:8]);
    endfunction

    function automatic int log_y(input int i);
        logic [16:0] e;
        e = log_entry(i);
        return int'(e[7:0]);
    endfunction

    function automatic bit corner_fn(input int mode, input int x, input int y);
        case (mode)
            0:       return (x == 10) && (y == 6);
            1:       return 1'b1;
            2:       return (x < 4) || (y < 4);
            3:       return (y == 4) && (x >= 4) && (x < 36);
            default: return ((x + y) % 7) == 0;
        endcase
    endfunction

    function automatic bit ready_fn(input int mode, input int x, input int y);
        case (mode)
            1:       return 1'b0;
            3:       return (y == 4) && (x >= 20) && (x < 36);
            default: return 1'b1;
        endcase
    endfunction

    // Compare DUT against the model, advance the model, then step one clock.
    task automatic tick();
        logic [16:0] dropped;
        check_eq("busy",       32'(busy),             32'(m_state == 1));
        check_eq("frame_done", 32'(frame_done),       32'(m_state == 2));
        check_eq("count",      32'(corner_count),     32'(m_cnt));
        check_eq("overflow",   32'(overflow),         32'(m_ovf));
        check_eq("valid",      32'(cif.corner_valid), 32'(sb_q.size() != 0));
        if (sb_q.size() != 0) begin
            check_eq("head_x", 32'(cif.corner_x), 32'(sb_q[0][16:8]));
            check_eq("head_y", 32'(cif.corner_y), 32'(sb_q[0][7:0]));
        end
        if (cif.corner_valid && cif.corner_ready && !rst) begin
            pop_log.push_back({cif.corner_x, cif.corner_y});
        end
        if (frame_done) n_done++;

        if (rst) begin
            m_state = 0; m_x = 0; m_y = 0; m_cnt = 0; m_ovf = 1'b0;
            sb_q.delete();
        end else begin
            if (sb_q.size() != 0 && cif.corner_ready) dropped = sb_q.pop_front();
            case (m_state)
                0: begin
                    if (frame_start) begin
                        m_state = 1; m_x = 0; m_y = 0; m_cnt = 0; m_ovf = 1'b0;
                    end
                end
                1: begin
                    if (pix_valid) begin
                        if (corner_in && m_x >= 4 && m_y >= 4) begin
                            if (m_cnt < 255) m_cnt++;
                            if (sb_q.size() < DEPTH) sb_q.push_back({9'(m_x - 2), 8'(m_y - 2)});
                            else m_ovf = 1'b1;
                        end
                        if (m_x == IW - 1) begin
                            m_x = 0;
                            if (m_y == IH - 1) m_state = 2;
                            else m_y++;
                        end else begin
                            m_x++;
                        end
                    end
                end
                default: m_state = 0;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        cif.corner_ready = 1'b1;
        pix_valid = 1'b0;
        corner_in = 1'b0;
        repeat (n) tick();
    endtask

    // One frame; stop_x/stop_y >= 0 asserts rst with that pixel and abandons the frame.
    task automatic run_frame(input int mode, input int gap_max, input bit extra_fs,
                             input int stop_x, input int stop_y);
        frame_start = 1'b1;
        pix_valid = 1'b0;
        corner_in = 1'b0;
        cif.corner_ready = ready_fn(mode, 0, 0);
        tick();
        frame_start = 1'b0;
        for (int y = 0; y < IH; y++) begin
            for (int x = 0; x < IW; x++) begin
                if (gap_max > 0) begin
                    int g;
                    g = int'($urandom_range(gap_max, 0));
                    for (int k = 0; k < g; k++) begin
                        pix_valid = 1'b0;
                        corner_in = 1'b1;
                        frame_start = extra_fs && ($urandom_range(3, 0) == 0);
                        tick();
                    end
                    frame_start = 1'b0;
                end
                pix_valid = 1'b1;
                corner_in = corner_fn(mode, x, y);
                cif.corner_ready = ready_fn(mode, x, y);
                if (x == stop_x && y == stop_y) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    pix_valid = 1'b0;
                    corner_in = 1'b0;
                    return;
                end
                tick();
            end
        end
        pix_valid = 1'b0;
        corner_in = 1'b0;
        frame_start = extra_fs;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        pix_valid = 1'b1;
        corner_in = 1'b1;
        cif.corner_ready = 1'b0;
        m_state = 0; m_x = 0; m_y = 0; m_cnt = 0; m_ovf = 1'b0;
        n_done = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy",   32'(busy),             0);
        check_eq("rst_done",   32'(frame_done),       0);
        check_eq("rst_valid",  32'(cif.corner_valid), 0);
        check_eq("rst_ovf",    32'(overflow),         0);
        check_eq("rst_count",  32'(corner_count),     0);
        check_eq("rst_x",      32'(cif.corner_x),     0);
        check_eq("rst_y",      32'(cif.corner_y),     0);
        rst = 1'b0;
        pix_valid = 1'b0;
        corner_in = 1'b0;
        tick();
        tick();

        // Single corner at raster (10,6)
        pop_log.delete();
        n_done = 0;
        run_frame(0, 0, 1'b0, -1, -1);
        check_eq("a_pops",  pop_log.size(), 1);
        check_eq("a_x",     log_x(0), 8);
        check_eq("a_y",     log_y(0), 4);
        check_eq("a_count", 32'(corner_count), 1);
        check_eq("a_done",  n_done, 1);

        // Corner everywhere, consumer stalled: overflow and saturation
        pop_log.delete();
        run_frame(1, 0, 1'b0, -1, -1);
        check_eq("b_ovf",   32'(overflow), 1);
        check_eq("b_count", 32'(corner_count), 255);
        drain(24);
        check_eq("b_pops",   pop_log.size(), 16);
        check_eq("b_x0",     log_x(0), 2);
        check_eq("b_y0",     log_y(0), 2);
        check_eq("b_x15",    log_x(15), 17);

        // Corners only on non-interior windows
        pop_log.delete();
        run_frame(2, 0, 1'b0, -1, -1);
        check_eq("c_count", 32'(corner_count), 0);
        check_eq("c_pops",  pop_log.size(), 0);
        check_eq("c_ovf",   32'(overflow), 0);

        // Full FIFO with simultaneous push and pop
        pop_log.delete();
        run_frame(3, 0, 1'b0, -1, -1);
        check_eq("d_ovf",   32'(overflow), 0);
        check_eq("d_count", 32'(corner_count), 32);
        check_eq("d_pops",  pop_log.size(), 16);
        drain(24);
        check_eq("d_total", pop_log.size(), 32);
        check_eq("d_x0",    log_x(0), 2);
        check_eq("d_x16",   log_x(16), 18);
        check_eq("d_y16",   log_y(16), 2);
        check_eq("d_x31",   log_x(31), 33);

        // Reset mid-frame, then restart
        pop_log.delete();
        n_done = 0;
        run_frame(1, 0, 1'b0, 30, 12);
        check_eq("e_busy",  32'(busy), 0);
        check_eq("e_valid", 32'(cif.corner_valid), 0);
        check_eq("e_ovf",   32'(overflow), 0);
        check_eq("e_count", 32'(corner_count), 0);
        repeat (4) tick();
        check_eq("e_done",  n_done, 0);
        pop_log.delete();
        run_frame(0, 0, 1'b0, -1, -1);
        check_eq("e_pops",  pop_log.size(), 1);
        check_eq("e_x",     log_x(0), 8);
        check_eq("e_y",     log_y(0), 4);
        check_eq("e_count2", 32'(corner_count), 1);

        // Same pattern without and with pix_valid gaps and stray frame_start
        exp_q.delete();
        for (int y = 4; y < IH; y++) begin
            for (int x = 4; x < IW; x++) begin
                if (corner_fn(4, x, y)) exp_q.push_back({9'(x - 2), 8'(y - 2)});
            end
        end
        for (int pass = 0; pass < 2; pass++) begin
            pop_log.delete();
            n_done = 0;
            run_frame(4, (pass == 0) ? 0 : 3, pass == 1, -1, -1);
            check_eq("f_pops",  pop_log.size(), exp_q.size());
            check_eq("f_count", 32'(corner_count), exp_q.size());
            check_eq("f_done",  n_done, 1);
            for (int i = 0; i < exp_q.size(); i++) begin
                check_eq("f_entry", 32'(log_entry(i)), 32'(exp_q[i]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/corner_scan_controller.md
CORNER_SCAN_CONTROLLER -- requirements
Module: corner_scan_controller

Interface
REQ-001 Parameter IMG_WIDTH, default 320, pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 240, lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 16, corner-coordinate FIFO entries (power of two, at least 2).
REQ-004 Port clk  input  1  single clock; all logic on the rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port frame_start  input  1  one-cycle pulse that arms a new frame scan.
REQ-007 Port pix_valid  input  1  one 5x5 window presented this cycle; its newest pixel is at the current raster position.
REQ-008 Port corner_in  input  1  corner-detector result for the window presented this cycle.
REQ-009 Port busy  output  1  high while scanning a frame.
REQ-010 Port frame_done  output  1  one-cycle pulse after the last pixel of a frame.
REQ-011 Port corner_count  output  8  corners accepted this frame, saturating at 255.
REQ-012 Port overflow  output  1  sticky; a corner was dropped because the FIFO was full.
REQ-013 Port corner_valid  output  1  FIFO is non-empty; head entry is on corner_x and corner_y.
REQ-014 Port corner_ready  input  1  consumer accepts the head entry when corner_valid is also high.
REQ-015 Port corner_x  output  9  window-centre column of the head entry.
REQ-016 Port corner_y  output  8  window-centre row of the head entry.

Function
REQ-017 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-018 IDLE->SCAN on frame_start; x, y, corner_count and overflow clear to 0; the FIFO is not cleared.
REQ-019 In SCAN each pix_valid SHALL advance x; x wraps from IMG_WIDTH-1 to 0 and increments y; no pix_valid holds x and y.
REQ-020 The window is interior when x>=4 and y>=4; corner_in SHALL be ignored for non-interior windows and when pix_valid is low.
REQ-021 An accepted corner SHALL push {x-2, y-2} (the window centre) into the FIFO in the same cycle.
REQ-022 A push attempted while the FIFO is full SHALL be dropped and set overflow; corner_count still increments.
REQ-023 Each accepted corner SHALL increment corner_count, which saturates at 255.
REQ-024 A pix_valid at x=IMG_WIDTH-1 and y=IMG_HEIGHT-1 SHALL be processed, then the FSM enters DONE and frame_done pulses the next cycle.
REQ-025 DONE->IDLE unconditionally after one cycle; corner_count and overflow hold until the next frame_start.
REQ-026 frame_start in SCAN or DONE SHALL be ignored.
REQ-027 busy = (state==SCAN).
REQ-028 The FIFO is first-word-fall-through: corner_valid, corner_x and corner_y are registered from the head entry.
REQ-029 Push and pop in the same cycle SHALL both take effect; a simultaneous push and pop on a full FIFO is not an overflow.
REQ-030 A pop on an empty FIFO has no effect; latency from push to corner_valid is 1 cycle.
REQ-031 The FIFO drains in all states; coordinates are unsigned, and x-2/y-2 are never negative because only interior windows are pushed.

Reset
REQ-032 rst SHALL return the FSM to IDLE and empty the FIFO.
REQ-033 Under rst, busy, frame_done, corner_valid, overflow, corner_count, corner_x and corner_y SHALL be 0.
REQ-034 rst SHALL take priority over every other input, including mid-frame, when the scan is abandoned without a frame_done.

Verification
REQ-035 Full frame with corner_in=1 only at raster (10,6), corner_ready=1 -> one entry (8,4), corner_count=1, frame_done exactly 1 cycle after pixel (319,239).
REQ-036 corner_in=1 on every pixel, corner_ready=0 -> 16 entries of which the first is (2,2), overflow=1, corner_count=255 (saturated).
REQ-037 corner_in=1 only at x<4 or y<4 -> no FIFO entries, corner_count=0.
REQ-038 Full FIFO with simultaneous push and pop -> occupancy stays 16, overflow stays 0, entries are in order.
REQ-039 rst asserted at pixel (100,50) -> next cycle IDLE, corner_valid=0, no frame_done; a following frame_start restarts at (0,0).
REQ-040 pix_valid gaps of random length and frame_start pulsed during SCAN -> identical coordinates and count to the gap-free run; the extra frame_start is ignored.
